// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game controller and the dino/obstacle renderers:
// game state encodings, score width and a saturating score increment helper.
// -----------------------------------------------------------------------------
package game_pkg;

   localparam int SCORE_W = 14;
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
   localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      GS_UNBEGIN = 2'b00,
      GS_RUNNING = 2'b01,
      GS_DEAD    = 2'b10,
      GS_ILLEGAL = 2'b11
   } gamestate_t;

   // Score stops at all-ones instead of wrapping back to zero.
   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
      return (s == SCORE_MAX) ? s : s + SCORE_ONE;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronizes a raw asynchronous push-button into clk, then only lets the
// debounced level follow once the synchronized input has differed from it for
// DEBOUNCE_CYCLES consecutive cycles.
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   btn_raw in   raw button, asynchronous
//   level   out  debounced level (registered)
//   rise    out  one-clk pulse on a debounced 0->1 change (registered)
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic rise
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      // Any cycle where the input agrees with the level restarts the count.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
// Top-level game state machine: UNBEGIN -> RUNNING -> DEAD -> UNBEGIN, jump
// request handshake with the dino renderer, duck level and frame score.
// Optional feature macro: GAME_CTRL_DUCK_EN (enables btn_down / lying).
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   refreshclk  in   frame tick, asynchronous, sampled as data
//   btn_jump    in   raw jump button
//   btn_down    in   raw duck button (unused unless GAME_CTRL_DUCK_EN)
//   isemptyDino in   dino layer transparent at current pixel
//   isemptyObs  in   obstacle layer transparent at current pixel
//   pix_valid   in   current pixel is visible
//   jump        out  jump request, held until the next frame tick consumes it
//   lying       out  duck level
//   gamestate   out  00 UNBEGIN, 01 RUNNING, 10 DEAD (also the FSM debug view)
//   score       out  frames survived in the current run
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module game_ctrl
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DEAD_HOLDOFF    = 30
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               refreshclk,
   input  logic               btn_jump,
   input  logic               btn_down,
   input  logic               isemptyDino,
   input  logic               isemptyObs,
   input  logic               pix_valid,
   output logic               jump,
   output logic               lying,
   output logic [1:0]         gamestate,
   output logic [SCORE_W-1:0] score
);

   localparam int HW = (DEAD_HOLDOFF > 0) ? $clog2(DEAD_HOLDOFF + 1) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(DEAD_HOLDOFF);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   // Frame tick: 2-flop synchronizer plus one flop for edge detection.
   logic ref_s1_q, ref_s2_q, ref_s3_q;
   logic tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         ref_s1_q <= 1'b0;
         ref_s2_q <= 1'b0;
         ref_s3_q <= 1'b0;
      end else begin
         ref_s1_q <= refreshclk;
         ref_s2_q <= ref_s1_q;
         ref_s3_q <= ref_s2_q;
      end
   end

   assign tick = ref_s2_q & ~ref_s3_q;

   logic jump_press;
   logic unused_jump_level;
   logic duck_level;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump_db (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_jump),
      .level   (unused_jump_level),
      .rise    (jump_press)
   );

`ifdef GAME_CTRL_DUCK_EN
   logic unused_down_rise;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_down),
      .level   (duck_level),
      .rise    (unused_down_rise)
   );
`else
   logic unused_btn_down;
   assign unused_btn_down = btn_down;
   assign duck_level      = 1'b0;
`endif

   gamestate_t         state_q, state_d;
   logic               jump_q, jump_d;
   logic               lying_q, lying_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic               collide;

   assign collide = pix_valid & ~isemptyDino & ~isemptyObs;

   always_comb begin
      state_d = state_q;
      jump_d  = jump_q;
      score_d = score_q;
      hold_d  = hold_q;
      case (state_q)
         GS_UNBEGIN: begin
            jump_d = 1'b0;
            // The starting press only starts the run; it is not a jump.
            if (jump_press) begin
               state_d = GS_RUNNING;
               score_d = '0;
            end
         end
         GS_RUNNING: begin
            // A collision wins over any press or tick in the same cycle.
            if (collide) begin
               state_d = GS_DEAD;
               jump_d  = 1'b0;
               hold_d  = '0;
            end else begin
               if (tick) begin
                  score_d = score_inc(score_q);
               end
               // Hold jump until a frame tick has seen it; presses while it
               // is pending are dropped.
               if (jump_q) begin
                  if (tick) begin
                     jump_d = 1'b0;
                  end
               end else if (jump_press) begin
                  jump_d = 1'b1;
               end
            end
         end
         GS_DEAD: begin
            jump_d = 1'b0;
            if (tick && (hold_q != HOLD_MAX)) begin
               hold_d = hold_q + HOLD_ONE;
            end
            if (jump_press && (hold_q == HOLD_MAX)) begin
               state_d = GS_UNBEGIN;
            end
         end
         default: begin
            state_d = GS_UNBEGIN;
            jump_d  = 1'b0;
         end
      endcase
      // Computed from next-state values so lying lines up with jump/gamestate.
      lying_d = (state_d == GS_RUNNING) && !jump_d && duck_level;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= GS_UNBEGIN;
         jump_q  <= 1'b0;
         lying_q <= 1'b0;
         score_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         jump_q  <= jump_d;
         lying_q <= lying_d;
         score_q <= score_d;
         hold_q  <= hold_d;
      end
   end

   assign jump      = jump_q;
   assign lying     = lying_q;
   assign gamestate = state_q;
   assign score     = score_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive clk cycles a raw button must be stable before its debounced level changes.
REQ-002 SHALL have parameter DEAD_HOLDOFF, default 30, meaning the number of refresh ticks after entering DEAD before a restart press is accepted.
REQ-003 SHALL have port clk  in  1  sole system clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port refreshclk  in  1  frame-rate tick, asynchronous to clk, sampled as data.
REQ-006 SHALL have ports btn_jump and btn_down  in  1 each  raw push-buttons, active-high, asynchronous.
REQ-007 SHALL have port isemptyDino  in  1  dino layer transparent at the current pixel.
REQ-008 SHALL have port isemptyObs  in  1  obstacle layer transparent at the current pixel.
REQ-009 SHALL have port pix_valid  in  1  current pixel is inside the visible area.
REQ-010 SHALL have port jump  out  1  jump request to the dino renderer, held until consumed.
REQ-011 SHALL have port lying  out  1  duck level to the dino renderer.
REQ-012 SHALL have port gamestate  out  2  00 UNBEGIN, 01 RUNNING, 10 DEAD.
REQ-013 SHALL have port score  out  14  frames survived in the current run.

Function
REQ-014 SHALL pass refreshclk through a 2-flop synchronizer, and a rising edge of the synchronized signal SHALL produce a one-clk tick.
REQ-015 SHALL debounce each button (2-flop sync, then stable-count), and a debounced 0->1 transition SHALL produce a one-clk press pulse.
REQ-016 SHALL move UNBEGIN->RUNNING on a jump press, without asserting jump for that press.
REQ-017 SHALL, in RUNNING, on a jump press, set jump=1, and SHALL clear jump on the first tick after it was set, so that jump is stable across at least one refreshclk edge.
REQ-018 SHALL ignore a jump press while jump is already 1.
REQ-019 SHALL, in RUNNING, move to DEAD on the clk following a cycle with pix_valid=1, isemptyDino=0 and isemptyObs=0.
REQ-020 SHALL, when a collision and a jump press occur in the same cycle, let DEAD win, leave jump unchanged, and clear jump on entry to DEAD.
REQ-021 SHALL, in DEAD, count ticks up to DEAD_HOLDOFF, ignore presses before the count is reached, and move DEAD->UNBEGIN on the first jump press after it is reached.
REQ-022 SHALL increment score by 1 per tick in RUNNING, saturating at 16383, and SHALL hold score in DEAD and UNBEGIN.
REQ-023 SHALL clear score to 0 on the UNBEGIN->RUNNING transition.
REQ-024 SHALL, in RUNNING, drive lying as the debounced btn_down level, forced to 0 while jump=1; outside RUNNING, lying SHALL be 0.
REQ-025 SHALL treat gamestate 11 as illegal and go to UNBEGIN on the next clk.
REQ-026 SHALL register all outputs; no output is combinational from an input.

Reset
REQ-027 SHALL, with rst=1 at a clk edge, set gamestate=00, jump=0, lying=0, score=0, the holdoff count to 0, the synchronizers to 0 and the debounced levels to 0.
REQ-028 SHALL let rst mid-jump or mid-holdoff abandon the operation, with no pending press surviving reset.

Configuration
REQ-029 SHALL, with macro GAME_CTRL_DUCK_EN defined, implement lying per REQ-024.
REQ-030 SHALL, without GAME_CTRL_DUCK_EN, tie lying to 0, instantiate no btn_down debouncer, and leave btn_down unused.

Structure
REQ-031 SHALL place the gamestate encodings (UNBEGIN, RUNNING, DEAD) and the score width in shared package game_pkg, which the dino and obstacle renderers also use.
REQ-032 SHALL implement debouncing in sub-module btn_debounce (parameter DEBOUNCE_CYCLES; outputs level and rise pulse), instantiated once per button.

Verification
REQ-033 SHALL verify: rst, then btn_jump held 20 clk (DEBOUNCE_CYCLES=16) -> gamestate 00->01 about 19 clk after assertion, jump stays 0, score=0.
REQ-034 SHALL verify: RUNNING, jump press, then one refreshclk edge -> jump=1 from press until the tick, 0 the next clk; a second press during jump=1 -> no effect.
REQ-035 SHALL verify: RUNNING, pix_valid=1, isemptyDino=0, isemptyObs=0 for 1 clk, together with a jump press -> gamestate=10 next clk, jump=0, score frozen.
REQ-036 SHALL verify: DEAD, DEAD_HOLDOFF=3, press after 2 ticks -> stays 10; press after 3 ticks -> 00; next press -> 01 with score=0.
REQ-037 SHALL verify: RUNNING, btn_down held -> lying=1 after debounce; during a pending jump -> lying=0; with GAME_CTRL_DUCK_EN undefined -> lying always 0.
REQ-038 SHALL verify: score forced to 16380, then 5 ticks -> score=16383; rst asserted mid-run -> all outputs 0 on the next clk.
